// File: rtl/stream_lockstep_pkg.sv
// Shared definitions for the N-stream lockstep checker: FSM encoding, stream limit, pointer sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stream_lockstep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Upper bound on stream count; also sets the width of the stream-index report.
   localparam int MAX_STREAMS = 8;

   // Address bits needed for a power-of-two skew FIFO (never less than 1).
   function automatic int ptr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/lockstep_fifo.sv
// Synchronous show-ahead FIFO holding one stream's bytes while it waits for the slowest stream.
// Latency: a pushed byte is visible on pop_data the cycle after the push.
// Backpressure: none upstream; a push to a full FIFO is accepted only alongside a pop, else dropped.
module lockstep_fifo
   import stream_lockstep_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SKEW_DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = ptr_width(SKEW_DEPTH);

   logic [WIDTH-1:0] mem [SKEW_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;

   // The extra top pointer bit separates full (bits differ) from empty (bits equal).
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // A clear empties the FIFO but still takes a byte presented in the same cycle, at slot 0.
   assign wr_en   = clear ? push : do_push;
   assign wr_addr = clear ? '0 : wr_ptr[AW-1:0];

   // Pointer update: clear wins over normal push/pop traffic.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= push ? (AW+1)'(1) : '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write port; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= push_data;
   end

endmodule

// File: rtl/stream_lockstep_checker.sv
// Lockstep comparator: streams 1..N-1 checked byte-by-byte against stream 0 per frame, skew absorbed by FIFOs.
// Latency: flags and byte_count update one cycle after a pop group; done follows DRAIN_TIMEOUT idle cycles.
// Backpressure: none; a stream leading by more than SKEW_DEPTH drops bytes and raises overflow.
// Optional macro LOCKSTEP_MISMATCH_COUNT_EN adds mismatch_count (groups with any differing stream).
module stream_lockstep_checker
   import stream_lockstep_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int NUM_STREAMS   = 2,
   parameter int SKEW_DEPTH    = 16,
   parameter int COUNT_WIDTH   = 24,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         frame_active,
   input  logic [NUM_STREAMS-1:0]       in_valid,
   input  logic [NUM_STREAMS*WIDTH-1:0] in_data,
   output logic [COUNT_WIDTH-1:0]       byte_count,
   output logic                         mismatch,
   output logic [2:0]                   mm_stream,
   output logic [COUNT_WIDTH-1:0]       mm_index,
   output logic [WIDTH-1:0]             mm_ref_data,
   output logic [WIDTH-1:0]             mm_dut_data,
   output logic                         overflow,
   output logic                         length_error,
   output logic                         done,
   output logic                         pass
`ifdef LOCKSTEP_MISMATCH_COUNT_EN
   ,
   output logic [COUNT_WIDTH-1:0]       mismatch_count
`endif
);

   localparam int                     IW      = $clog2(DRAIN_TIMEOUT + 1);
   localparam int                     SW      = $clog2(MAX_STREAMS);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                 state;
   state_t                 next_state;
   logic                   frame_prev;
   logic                   rise;
   logic                   fall;
   logic                   start;
   logic                   finish;
   logic                   restart_set;
   logic                   restart;
   logic                   push_en;
   logic                   pop_en;
   logic                   ready;
   logic                   pop_all;
   logic                   any_fill;
   logic                   timeout;
   logic [IW-1:0]          idle_cnt;
   logic [NUM_STREAMS-1:0] push;
   logic [NUM_STREAMS-1:0] full;
   logic [NUM_STREAMS-1:0] empty;
   logic [WIDTH-1:0]       head [NUM_STREAMS];
   logic [NUM_STREAMS-1:0] diff;
   logic [SW-1:0]          first_stream;
   logic [WIDTH-1:0]       first_dut;

   assign rise     = frame_active & ~frame_prev;
   assign fall     = ~frame_active & frame_prev;
   assign ready    = &(~empty);
   assign any_fill = |(~empty);
   assign pop_all  = pop_en & ready;
   assign push     = in_valid & {NUM_STREAMS{push_en}};

   // Drain ends only once input has been quiet long enough and no pop group is still in flight.
   assign timeout = (idle_cnt == IW'(DRAIN_TIMEOUT)) && ~|in_valid && ~ready;

   // One skew FIFO per stream; all pop together when every stream has a byte ready.
   for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_fifo
      lockstep_fifo #(
         .WIDTH      (WIDTH),
         .SKEW_DEPTH (SKEW_DEPTH)
      ) u_fifo (
         .clock     (clock),
         .reset     (reset),
         .clear     (start),
         .push      (push[k]),
         .push_data (in_data[k*WIDTH +: WIDTH]),
         .pop       (pop_all),
         .pop_data  (head[k]),
         .full      (full[k]),
         .empty     (empty[k])
      );
   end

   // Compare FIFO heads with the reference; scanning downward leaves the lowest differing stream.
   always_comb begin
      diff         = '0;
      first_stream = '0;
      first_dut    = '0;
      for (int k = NUM_STREAMS - 1; k >= 1; k--) begin
         if (head[k] != head[0]) begin
            diff[k]      = 1'b1;
            first_stream = SW'(k);
            first_dut    = head[k];
         end
      end
   end

   // Next-state and traffic enables. A new frame arriving during drain closes the
   // old frame at once; bytes of that edge cycle are not attributed to either frame.
   always_comb begin
      next_state  = state;
      start       = 1'b0;
      finish      = 1'b0;
      restart_set = 1'b0;
      push_en     = 1'b0;
      pop_en      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               next_state = ST_RUN;
               start      = 1'b1;
               push_en    = 1'b1;
            end
         end
         ST_RUN: begin
            push_en = 1'b1;
            pop_en  = 1'b1;
            if (fall) next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (rise) begin
               next_state  = ST_DONE;
               finish      = 1'b1;
               restart_set = 1'b1;
            end else begin
               push_en = 1'b1;
               pop_en  = 1'b1;
               if (timeout) begin
                  next_state = ST_DONE;
                  finish     = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (restart || rise) begin
               next_state = ST_RUN;
               start      = 1'b1;
               push_en    = 1'b1;
            end else begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Edge-detect history follows the input even through reset, so a frame that is
   // already high when reset lifts is never mistaken for a new frame start.
   always_ff @(posedge clock) begin
      frame_prev <= frame_active;
   end

   // Remember that the verdict was forced by a new frame so DONE hands straight back to RUN.
   always_ff @(posedge clock) begin
      if (reset) restart <= 1'b0;
      else       restart <= restart_set;
   end

   // Idle counter: only meaningful in drain, cleared by any incoming byte, saturates at the timeout.
   always_ff @(posedge clock) begin
      if (reset || state != ST_DRAIN || |in_valid) idle_cnt <= '0;
      else if (idle_cnt != IW'(DRAIN_TIMEOUT))     idle_cnt <= idle_cnt + 1'b1;
   end

   // Per-frame results: sticky flags, first-mismatch capture, byte count and verdict.
   always_ff @(posedge clock) begin
      if (reset || start) begin
         byte_count   <= '0;
         mismatch     <= 1'b0;
         mm_stream    <= '0;
         mm_index     <= '0;
         mm_ref_data  <= '0;
         mm_dut_data  <= '0;
         overflow     <= 1'b0;
         length_error <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
      end else begin
         done <= finish;
         if (|(push & full) && !pop_all) overflow <= 1'b1;
         if (pop_all) begin
            if (byte_count != CNT_MAX) byte_count <= byte_count + 1'b1;
            if (|diff) begin
               mismatch <= 1'b1;
               if (!mismatch) begin
                  mm_stream   <= 3'(first_stream);
                  mm_index    <= byte_count;
                  mm_ref_data <= head[0];
                  mm_dut_data <= first_dut;
               end
            end
         end
         // No push or pop happens in a finish cycle, so the flags seen here are final.
         if (finish) begin
            if (any_fill) length_error <= 1'b1;
            pass <= ~(mismatch | overflow | length_error | any_fill);
         end
      end
   end

`ifdef LOCKSTEP_MISMATCH_COUNT_EN
   // Count of compare groups with at least one differing stream, saturating.
   always_ff @(posedge clock) begin
      if (reset || start) begin
         mismatch_count <= '0;
      end else if (pop_all && |diff && mismatch_count != CNT_MAX) begin
         mismatch_count <= mismatch_count + 1'b1;
      end
   end
`endif

endmodule

// File: doc/stream_lockstep_checker.md
Name: stream_lockstep_checker

Overview:
- Synthesizable N-stream lockstep comparator for compressor byte streams.
- Typical use: RTL, synthesized and alternate compressor instances all feed it; it replaces ad-hoc buffer-and-diff benches and works on-FPGA.
- Each stream is buffered in a skew FIFO. Stream 0 is the reference. Streams 1..N-1 are compared to it byte by byte, per frame, with a bounded latency skew tolerated.
- Reports first-mismatch details, overflow and length errors, and a per-frame pass/fail.

Parameters:
- WIDTH, 8, data byte width.
- NUM_STREAMS, 2, stream count (2..8); stream 0 is the reference.
- SKEW_DEPTH, 16, per-stream FIFO depth (power of 2); the maximum tolerated lead of any stream.
- COUNT_WIDTH, 24, width of byte index/count.
- DRAIN_TIMEOUT, 64, number of idle cycles after frame end before the final verdict.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- frame_active, in, 1, high while a frame is in progress (compressor vsync); sampled in the clock domain.
- in_valid, in, NUM_STREAMS, per-stream byte strobe (compressor data_good).
- in_data, in, NUM_STREAMS*WIDTH, stream k occupies bits [k*WIDTH +: WIDTH].
- byte_count, out, COUNT_WIDTH, number of byte groups compared this frame.
- mismatch, out, 1, sticky: at least one compared byte differed.
- mm_stream, out, 3, stream index of the first mismatch.
- mm_index, out, COUNT_WIDTH, byte index of the first mismatch.
- mm_ref_data, out, WIDTH, reference byte at the first mismatch.
- mm_dut_data, out, WIDTH, differing byte at the first mismatch.
- overflow, out, 1, sticky: a push occurred to a full FIFO.
- length_error, out, 1, sticky: streams ended with unequal byte counts.
- done, out, 1, one-cycle pulse when the verdict is final.
- pass, out, 1, valid from done until the next frame start; high iff no error flag is set.

Behaviour:
- Reset: all outputs are 0, FIFOs are emptied, FSM goes to IDLE. Reset mid-frame discards everything; checking restarts only at the next frame_active rising edge.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN: on a rising edge of frame_active, detected against a registered previous value.
  - Entering RUN clears FIFOs, byte_count, all sticky flags, mm_* and pass in that same cycle.
  - Bytes with in_valid high in the edge cycle are pushed.
- RUN: each stream pushes in_data when in_valid is high.
  - When every FIFO is non-empty (show-ahead), all FIFOs pop together.
  - The compare result is registered: flags and byte_count update 1 cycle after the pop.
  - byte_count increments once per pop group and saturates at all-ones.
- First mismatch: if any stream k>0 differs from stream 0, set mismatch and capture mm_* only if mismatch was previously 0. Lowest k wins when several streams differ in the same group.
- FIFO push/pop rules:
  - Push to a full FIFO with no simultaneous pop: the byte is dropped and overflow is set.
  - Push to a full FIFO with a simultaneous pop: accepted.
  - Pointers wrap modulo SKEW_DEPTH, with an extra wrap bit to distinguish full from empty.
- RUN to DRAIN: on a falling edge of frame_active.
- DRAIN: pushes and pops continue. An idle counter resets on any in_valid bit and otherwise counts up.
  - If a frame_active rising edge arrives here, the current frame is evaluated immediately (verdict, then done) and the FSM re-enters RUN in the next cycle.
- DRAIN to DONE: when the idle counter reaches DRAIN_TIMEOUT and no compare is pending.
  - If any FIFO is non-empty at that point, set length_error.
- DONE: assert done for 1 cycle and set pass = ~(mismatch|overflow|length_error), then go to IDLE. pass and the flags hold until the next frame start.
- All widths are unsigned. mm_stream is zero-extended.

Optional Feature:
- Macro: LOCKSTEP_MISMATCH_COUNT_EN.
- When defined: adds output mismatch_count (COUNT_WIDTH). It counts compare groups with at least one differing stream, saturates, and clears at frame start.
- When undefined: the port and counter do not exist; only first-mismatch capture is present.

Decomposition:
- Shared package stream_lockstep_pkg holds:
  - FSM state encoding (IDLE/RUN/DRAIN/DONE, 2-bit);
  - the MAX_STREAMS=8 constant;
  - a function computing pointer width from SKEW_DEPTH.
- One sub-module: lockstep_fifo, a synchronous show-ahead FIFO (WIDTH, SKEW_DEPTH) with push, pop, full, empty. It is instantiated NUM_STREAMS times via generate.

Test Plan:
- Identical streams: frame_active high, 100 bytes 0x00..0x63 on both streams, same cycle, then frame_active low → done after DRAIN_TIMEOUT idle cycles, pass=1, byte_count=100, all flags 0.
- Skew: stream 1 lags stream 0 by 10 cycles, same 100 bytes → pass=1, byte_count=100, overflow=0.
- Mismatch: stream 1 byte 37 = 0xA5 versus reference 0x25, and byte 50 also differs → mismatch=1, mm_stream=1, mm_index=37, mm_ref_data=0x25, mm_dut_data=0xA5, pass=0.
- Overflow/length: stream 0 sends 20 bytes while stream 1 sends none (SKEW_DEPTH=16) → overflow=1, length_error=1, pass=0.
- Three streams, both differing: NUM_STREAMS=3, streams 1 and 2 both differ at index 5 → mm_stream=1. A second frame with clean data → flags cleared at frame start, pass=1.
- Reset mid-frame: assert reset after 30 bytes → all outputs 0 next cycle, no done pulse. The next full frame checks normally with byte_count counted from 0.
